// File: rtl/birth_seq_ctrl.sv
// birth_seq_ctrl: steps a 3-bit index (cnt) through an external
// birth-digit converter and drives a 7-segment display from the digit it
// returns.
//
// Each index is held for DIV clock cycles. The sequence can run in either
// direction, wrap continuously or make a single pass, be frozen with pause,
// and be restarted at any time with start.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      1-cycle begin/restart request (beats pause and step ticks)
//   pause      level, freezes sequencing while high
//   loop       level, 1 = wrap, 0 = one pass (looked at on step edges only)
//   dir        0 = ascending, 1 = descending (latched on accepted start)
//   cnt        registered index to the converter
//   birth_num  BCD digit from the converter for the current cnt
//   seg        registered active-low segments, gfedcba
//   busy       high in RUN or PAUSE
//   done       1-cycle pulse at the end of a one-pass sequence
module birth_seq_ctrl #(
  parameter int unsigned DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       loop,
  input  logic       dir,
  output logic [2:0] cnt,
  input  logic [3:0] birth_num,
  output logic [6:0] seg,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [6:0] BLANK = 7'b111_1111;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [2:0]    cnt_n;
  logic          dir_q, dir_n;
  logic          last;
  logic [6:0]    seg_dec;

  // The last index depends on the direction latched at start.
  assign last = dir_q ? (cnt == 3'd0) : (cnt == 3'd7);
  assign busy = (state == RUN) || (state == PAUSE);

  always_comb begin
    seg_dec = BLANK;
    case (birth_num)
      4'd0: seg_dec = 7'b100_0000;
      4'd1: seg_dec = 7'b111_1001;
      4'd2: seg_dec = 7'b010_0100;
      4'd3: seg_dec = 7'b011_0000;
      4'd4: seg_dec = 7'b001_1001;
      4'd5: seg_dec = 7'b001_0010;
      4'd6: seg_dec = 7'b000_0010;
      4'd7: seg_dec = 7'b101_1000;
      4'd8: seg_dec = 7'b000_0000;
      4'd9: seg_dec = 7'b001_0000;
      default: seg_dec = BLANK;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    presc_n = presc;
    dir_n   = dir_q;
    if (start) begin
      dir_n   = dir;
      cnt_n   = dir ? 3'd7 : 3'd0;
      presc_n = '0;
      state_n = RUN;
    end else begin
      case (state)
        RUN: begin
          if (pause) begin
            state_n = PAUSE;
          end else if (presc == PRESC_MAX) begin
            presc_n = '0;
            if (last && !loop) begin
              state_n = DONE;
            end else begin
              // 3-bit arithmetic makes the wrap 7->0 / 0->7 implicit.
              cnt_n = dir_q ? cnt - 3'd1 : cnt + 3'd1;
            end
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        PAUSE: if (!pause) state_n = RUN;
        DONE: begin
          state_n = IDLE;
          cnt_n   = 3'd0;
          presc_n = '0;
        end
        default: ;
      endcase
    end
  end

  // Display is refreshed from the converter every cycle outside IDLE.
  // Keying the blanking on the next state means seg is already blank on
  // the first IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
      presc <= '0;
      dir_q <= 1'b0;
      seg   <= BLANK;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      presc <= presc_n;
      dir_q <= dir_n;
      seg   <= (state_n == IDLE) ? BLANK : seg_dec;
      done  <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_birth_seq_ctrl.sv
// tb_birth_seq_ctrl: directed scenarios followed by randomized stimulus.
// All outputs are compared against a behavioural model after every clock.
module tb_birth_seq_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, pause = 1'b0, loop = 1'b0, dir = 1'b0;
  logic       force_a = 1'b0;
  logic [2:0] cnt;
  logic [3:0] birth_num;
  logic [6:0] seg;
  logic       busy, done;

  int checks = 0, failures = 0;
  int ndone, done_at, cyc;

  // Converter model: digits 1,9,9,9,0,3,2,1 for indices 0..7.
  int conv [8] = '{1, 9, 9, 9, 0, 3, 2, 1};
  int segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                      7'h00, 7'h10, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f};

  assign birth_num = force_a ? 4'hA : 4'(conv[cnt]);

  birth_seq_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .loop(loop),
    .dir(dir), .cnt(cnt), .birth_num(birth_num), .seg(seg), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: activity flags, index, phase within the digit.
  bit m_active, m_frozen, m_done, m_dir;
  int m_cnt, m_phase, m_seg;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_frozen = 0; m_done = 0; m_dir = 0;
    m_cnt = 0; m_phase = 0; m_seg = 7'h7f;
  endtask

  task automatic model_edge();
    int dig;
    bit was_done;
    if (!rst_n) begin
      model_reset();
      return;
    end
    dig = force_a ? 10 : conv[m_cnt];
    was_done = m_done;
    m_done = 0;
    if (start) begin
      m_active = 1; m_frozen = 0; m_dir = dir;
      m_cnt = dir ? 7 : 0; m_phase = 0;
    end else if (was_done) begin
      m_cnt = 0; m_phase = 0;
    end else if (m_active && m_frozen) begin
      if (!pause) m_frozen = 0;
    end else if (m_active) begin
      if (pause) m_frozen = 1;
      else if (m_phase < DIV - 1) m_phase++;
      else begin
        m_phase = 0;
        if (!loop && m_cnt == (m_dir ? 0 : 7)) begin
          m_active = 0; m_done = 1;
        end else m_cnt = (m_cnt + (m_dir ? 7 : 1)) % 8;
      end
    end
    m_seg = (m_active || m_done) ? segtab[dig] : 7'h7f;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("cnt", cnt, m_cnt);
    chk("seg", seg, m_seg);
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    cyc++;
    if (done) begin
      ndone++;
      done_at = cyc;
    end
  endtask

  task automatic pulse_start(input bit d, input bit l);
    dir = d; loop = l; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; cyc = 0; done_at = -1;
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_cnt"}, cnt, 0);
    chk({tag, "_seg"}, seg, 7'h7f);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    model_reset();
  endtask

  initial begin
    int c0, guard;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cnt", cnt, 0);
    chk("rst_seg", seg, 7'h7f);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // One ascending pass.
    pulse_start(0, 0);
    repeat (40) tick();
    chk("pass_done_cnt", ndone, 1);
    chk("pass_done_at", done_at, 32);

    // Descending wrap, dir toggling mid-run is ignored.
    pulse_start(1, 1);
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 5) dir = ~dir;
      tick();
    end
    chk("loop_no_done", ndone, 0);

    // Pause when phase is 2.
    pulse_start(0, 1);
    guard = 0;
    while (!(m_active && !m_frozen && m_phase == 2) && guard < 20) begin
      tick(); guard++;
    end
    chk("pause_reach", guard < 20, 1);
    c0 = m_cnt;
    pause = 1'b1;
    repeat (10) tick();
    chk("pause_frozen", cnt, c0);
    pause = 1'b0;
    tick(); tick();
    chk("pause_hold", cnt, c0);
    tick();
    chk("pause_step", cnt, (c0 + 1) % 8);

    // Restart at cnt=5 then full pass.
    pulse_start(0, 0);
    guard = 0;
    while (m_cnt != 5 && guard < 40) begin
      tick(); guard++;
    end
    chk("restart_reach", cnt, 5);
    pulse_start(0, 0);
    chk("restart_cnt", cnt, 0);
    repeat (34) tick();
    chk("restart_done_cnt", ndone, 1);
    chk("restart_done_at", done_at, 32);

    // Out-of-range digit blanks the display.
    pulse_start(0, 1);
    repeat (3) tick();
    force_a = 1'b1;
    tick();
    chk("force_a_seg", seg, 7'h7f);
    force_a = 1'b0;
    tick();

    // Reset at cnt=3 mid-run.
    pulse_start(0, 0);
    guard = 0;
    while (m_cnt != 3 && guard < 40) begin
      tick(); guard++;
    end
    chk("rst3_reach", cnt, 3);
    async_reset_check("rst3");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();
    chk("rst3_no_done", ndone, 0);

    // Randomized stimulus.
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      if ($urandom_range(0, 29) == 0) loop = ~loop;
      dir     = $urandom_range(0, 1);
      force_a = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 399) == 0) begin
        start = 1'b0;
        async_reset_check("rnd_rst");
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
